multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers (2..64).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004 SHALL have derived address width AW = clog2(NREGS), taken from the shared package.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset; reset is synchronous and active-high.
REQ-007 SHALL have port rd_addr, input, NREAD*AW, packed read addresses, port k at [k*AW +: AW].
REQ-008 SHALL have port rd_data, output, NREAD*XLEN, packed read data, port k at [k*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy, output, NREAD, per-read-port scoreboard busy flag.
REQ-010 SHALL have ports we0/wa0/wd0, input, 1/AW/XLEN, write port 0 enable/address/data.
REQ-011 SHALL have ports we1/wa1/wd1, input, 1/AW/XLEN, write port 1 enable/address/data.
REQ-012 SHALL have ports sb_set/sb_addr, input, 1/AW, scoreboard mark-busy request and target.

Function
REQ-013 Reads SHALL be combinational, with zero latency from rd_addr to rd_data and rd_busy.
REQ-014 Register 0 SHALL always read 0 and never report busy; writes and sb_set to address 0 SHALL be ignored.
REQ-015 An address >= NREGS SHALL read 0 and not busy; writes and sets to it SHALL be ignored.
REQ-016 A write with weN=1 SHALL update the register on the rising clk edge; the new value is visible on the next cycle.
REQ-017 Simultaneous writes from both ports to the same address SHALL store wd1 (port 1 wins).
REQ-018 Simultaneous writes to different addresses SHALL both commit in the same cycle.
REQ-019 sb_set=1 SHALL set the busy bit of sb_addr on the clock edge.
REQ-020 A write on either port SHALL clear the busy bit of its address on the same edge.
REQ-021 If set and clear hit the same address in the same cycle, set SHALL win and the bit stays busy.
REQ-022 All NREAD ports SHALL be independent, and any two ports SHALL be allowed the same address.

Reset
REQ-023 While reset=1 at a clk edge, all registers SHALL become 0 and all busy bits SHALL clear.
REQ-024 While reset=1, writes and sb_set SHALL be ignored.
REQ-025 Reads SHALL stay combinational during reset and SHALL return 0 and not-busy from the first edge with reset=1.
REQ-026 Reset asserted mid-sequence SHALL discard that cycle's writes; no partial state SHALL remain.

Configuration
REQ-027 Macro RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With RF_BYPASS_EN defined, a read matching a same-cycle write address SHALL return that write's data, with port 1 taking priority, and rd_busy=0.
REQ-029 Bypass SHALL never apply to address 0 or while reset=1.
REQ-030 Without RF_BYPASS_EN, reads SHALL return the stored value and current busy state only.

Structure
REQ-031 Package rf_pkg SHALL hold the clog2 function, AW derivation, and NREGS/NREAD limit constants.
REQ-032 Scoreboard bits and the set/clear priority logic SHALL live in sub-module rf_scoreboard, with storage and read muxing in the top module.

Verification
REQ-033 reset=1 for 3 cycles, then read x1..x31 -> all 0, rd_busy=0.
REQ-034 we0=1, wa0=5, wd0=100, then rd_addr port0=5 -> 100 on the next cycle; with RF_BYPASS_EN -> 100 in the same cycle.
REQ-035 we0 to x7=0xAAAA_0000 and we1 to x7=0x0000_5555 in the same cycle -> x7 reads 0x0000_5555.
REQ-036 write x0=0xFFFF_FFFF and sb_set x0 -> x0 reads 0, rd_busy=0.
REQ-037 sb_set x3, next cycle we1 x3=42 with sb_set x3 -> x3 busy, reads 42; next cycle we0 x3=43 -> busy=0, reads 43.
REQ-038 write x9=77, then assert reset with we0 x9=88 in the same cycle -> x9 reads 0 after the edge.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the multiport register file
//
// Purpose : parameter limits, clog2, address-width derivation and the
//           "is this an architectural, writable/readable address" test
//           shared by multiport_register_file and rf_scoreboard.
// Ports   : none (package).
package rf_pkg;

   localparam int NREGS_MIN = 2;
   localparam int NREGS_MAX = 64;
   localparam int NREAD_MIN = 1;
   localparam int NREAD_MAX = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Address width never drops below one bit, even for tiny files.
   function automatic int rf_aw(input int nregs);
      return (nregs < NREGS_MIN) ? 1 : clog2(nregs);
   endfunction

   // Register 0 and addresses beyond the file behave as hard-wired zero.
   function automatic logic addr_ok(input int a, input int nregs);
      return (a != 0) && (a < nregs);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with set-over-clear priority
//
// Purpose : one busy bit per architectural register. sb_set marks a register
//           busy; a write on either port clears it; a set and a clear to the
//           same register on the same edge leave it busy.
// Ports   : clk, reset (sync, active-high)
//           sb_set/sb_addr   mark-busy request
//           we0/wa0, we1/wa1 write ports (clear sources)
//           busy[NREGS]      current busy vector, bit 0 always 0
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sb_set,
   input  logic [AW-1:0]    sb_addr,
   input  logic             we0,
   input  logic [AW-1:0]    wa0,
   input  logic             we1,
   input  logic [AW-1:0]    wa1,
   output logic [NREGS-1:0] busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Loop starts at 1 and stops below NREGS, so address 0 and out-of-range
   // addresses can never match and are ignored for free.
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NREGS; i++) begin
         if ((we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i))))
            busy_d[i] = 1'b0;
         // Applied after the clear so a same-edge set wins.
         if (sb_set && (sb_addr == AW'(i)))
            busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - 2-write / NREAD-read register file with scoreboard
//
// Purpose : NREGS x XLEN register file, x0 hard-wired to zero, two write
//           ports (port 1 wins on a same-address collision), NREAD
//           combinational read ports each reporting the register's busy bit.
// Macro   : RF_BYPASS_EN - when defined, a read whose address matches a
//           same-cycle write returns that write's data (port 1 first) and
//           reports not-busy; never for x0 or while reset is high.
// Ports   : clk, reset (sync, active-high)
//           rd_addr[NREAD*AW]   packed read addresses, port k at [k*AW +: AW]
//           rd_data[NREAD*XLEN] packed read data,      port k at [k*XLEN +: XLEN]
//           rd_busy[NREAD]      per-port busy flag
//           we0/wa0/wd0, we1/wa1/wd1  write ports
//           sb_set/sb_addr      scoreboard mark-busy request
module multiport_register_file
   import rf_pkg::*;
#(
   parameter int  XLEN  = 32,
   parameter int  NREGS = 32,
   parameter int  NREAD = 2,
   localparam int AW    = rf_aw(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREAD*AW-1:0]   rd_addr,
   output logic [NREAD*XLEN-1:0] rd_data,
   output logic [NREAD-1:0]      rd_busy,
   input  logic                  we0,
   input  logic [AW-1:0]         wa0,
   input  logic [XLEN-1:0]       wd0,
   input  logic                  we1,
   input  logic [AW-1:0]         wa1,
   input  logic [XLEN-1:0]       wd1,
   input  logic                  sb_set,
   input  logic [AW-1:0]         sb_addr
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy;

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk     (clk),
      .reset   (reset),
      .sb_set  (sb_set),
      .sb_addr (sb_addr),
      .we0     (we0),
      .wa0     (wa0),
      .we1     (we1),
      .wa1     (wa1),
      .busy    (busy)
   );

   // Port 1 is applied last so it wins a same-address collision.
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < NREGS; i++) begin
         if (we0 && (wa0 == AW'(i))) regs_d[i] = wd0;
         if (we1 && (wa1 == AW'(i))) regs_d[i] = wd1;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         regs_q <= '{default: '0};
      else
         regs_q <= regs_d;
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = rd_addr[k*AW +: AW];

      always_comb begin
         data = '0;
         bsy  = 1'b0;
         if (addr_ok(int'(addr), NREGS)) begin
            data = regs_q[addr];
            bsy  = busy[addr];
`ifdef RF_BYPASS_EN
            if (!reset && we1 && (wa1 == addr)) begin
               data = wd1;
               bsy  = 1'b0;
            end else if (!reset && we0 && (wa0 == addr)) begin
               data = wd0;
               bsy  = 1'b0;
            end
`endif
         end
      end

      assign rd_data[k*XLEN +: XLEN] = data;
      assign rd_busy[k]              = bsy;
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// tb/tb_multiport_register_file.sv - directed self-checking bench for multiport_register_file
module tb_multiport_register_file;

   localparam int XLEN  = 32;
   localparam int NREAD = 2;
   localparam int AW    = 5;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREAD*AW-1:0]   rd_addr;
   logic [NREAD*XLEN-1:0] rd_data;
   logic [NREAD-1:0]      rd_busy;
   logic                  we0, we1, sb_set;
   logic [AW-1:0]         wa0, wa1, sb_addr;
   logic [XLEN-1:0]       wd0, wd1;

   int checks = 0;
   int passed = 0;

   multiport_register_file #(
      .XLEN  (XLEN),
      .NREGS (32),
      .NREAD (NREAD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_busy (rd_busy),
      .we0     (we0),
      .wa0     (wa0),
      .wd0     (wd0),
      .we1     (we1),
      .wa1     (wa1),
      .wd1     (wd1),
      .sb_set  (sb_set),
      .sb_addr (sb_addr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      sb_set = 1'b0; sb_addr = '0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr[0*AW +: AW] = AW'(a0);
      rd_addr[1*AW +: AW] = AW'(a1);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rd_addr = '0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      for (int a = 1; a < 32; a++) begin
         set_rd(a, 32 - a);
         checks++;
         if (rd_data !== 64'd0 || rd_busy !== 2'b00)
            $display("FAIL reset_read x%0d: data=%h busy=%b required data=0 busy=00", a, rd_data, rd_busy);
         else passed++;
      end
   endtask

   task automatic test_write_read();
      logic [31:0] exp_same;
`ifdef RF_BYPASS_EN
      exp_same = 32'd100;
`else
      exp_same = 32'd0;
`endif
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'd100;
      set_rd(5, 0);
      checks++;
      if (rd_data[31:0] !== exp_same)
         $display("FAIL write_same_cycle: data=%0d required %0d", rd_data[31:0], exp_same);
      else passed++;
      tick();
      idle();
      set_rd(5, 0);
      checks++;
      if (rd_data[31:0] !== 32'd100 || rd_data[63:32] !== 32'd0)
         $display("FAIL write_next_cycle: p0=%0d p1=%0d required 100 and 0", rd_data[31:0], rd_data[63:32]);
      else passed++;
   endtask

   task automatic test_same_addr();
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_0000;
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_5555;
`ifdef RF_BYPASS_EN
      set_rd(7, 7);
      checks++;
      if (rd_data[31:0] !== 32'h0000_5555)
         $display("FAIL bypass_port1_priority: data=%h required 00005555", rd_data[31:0]);
      else passed++;
`endif
      tick();
      idle();
      set_rd(0, 7);
      checks++;
      if (rd_data[63:32] !== 32'h0000_5555)
         $display("FAIL same_addr_port1_wins: data=%h required 00005555", rd_data[63:32]);
      else passed++;
   endtask

   task automatic test_dual_write();
      we0 = 1'b1; wa0 = 5'd10; wd0 = 32'd11;
      we1 = 1'b1; wa1 = 5'd11; wd1 = 32'd22;
      tick();
      idle();
      set_rd(10, 11);
      checks++;
      if (rd_data[31:0] !== 32'd11 || rd_data[63:32] !== 32'd22)
         $display("FAIL dual_write: p0=%0d p1=%0d required 11 and 22", rd_data[31:0], rd_data[63:32]);
      else passed++;
   endtask

   task automatic test_x0();
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
      sb_set = 1'b1; sb_addr = 5'd0;
      set_rd(0, 0);
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00)
         $display("FAIL x0_same_cycle: data=%h busy=%b required 0 and 00", rd_data, rd_busy);
      else passed++;
      tick();
      idle();
      set_rd(0, 0);
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00)
         $display("FAIL x0_after_write: data=%h busy=%b required 0 and 00", rd_data, rd_busy);
      else passed++;
   endtask

   task automatic test_scoreboard();
      sb_set = 1'b1; sb_addr = 5'd3;
      tick();
      idle();
      set_rd(3, 4);
      checks++;
      if (rd_busy !== 2'b01 || rd_data[31:0] !== 32'd0)
         $display("FAIL sb_set: busy=%b data=%0d required 01 and 0", rd_busy, rd_data[31:0]);
      else passed++;
      we1 = 1'b1; wa1 = 5'd3; wd1 = 32'd42;
      sb_set = 1'b1; sb_addr = 5'd3;
      tick();
      idle();
      set_rd(3, 3);
      checks++;
      if (rd_busy !== 2'b11 || rd_data[31:0] !== 32'd42)
         $display("FAIL sb_set_wins: busy=%b data=%0d required 11 and 42", rd_busy, rd_data[31:0]);
      else passed++;
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd43;
      tick();
      idle();
      set_rd(3, 3);
      checks++;
      if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'd43 || rd_data[63:32] !== 32'd43)
         $display("FAIL write_clears_busy: busy=%b p0=%0d p1=%0d required 00 43 43", rd_busy, rd_data[31:0], rd_data[63:32]);
      else passed++;
      // Busy held for a register with no pending write
      sb_set = 1'b1; sb_addr = 5'd12;
      tick();
      idle();
      tick();
      set_rd(12, 3);
      checks++;
      if (rd_busy !== 2'b01)
         $display("FAIL busy_holds: busy=%b required 01", rd_busy);
      else passed++;
   endtask

   task automatic test_reset_mid();
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'd77;
      tick();
      idle();
      set_rd(9, 0);
      checks++;
      if (rd_data[31:0] !== 32'd77)
         $display("FAIL pre_reset_write: data=%0d required 77", rd_data[31:0]);
      else passed++;
      reset = 1'b1;
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'd88;
      sb_set = 1'b1; sb_addr = 5'd4;
      set_rd(9, 9);
      checks++;
      if (rd_data[31:0] !== 32'd77 || rd_busy !== 2'b00)
         $display("FAIL no_bypass_in_reset: data=%0d busy=%b required 77 and 00", rd_data[31:0], rd_busy);
      else passed++;
      tick();
      reset = 1'b0;
      idle();
      set_rd(9, 4);
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00)
         $display("FAIL reset_mid: data=%h busy=%b required 0 and 00", rd_data, rd_busy);
      else passed++;
      set_rd(12, 7);
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00)
         $display("FAIL reset_clears_all: data=%h busy=%b required 0 and 00", rd_data, rd_busy);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_same_addr();
      test_dual_write();
      test_x0();
      test_scoreboard();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
